// File: rtl/prbs31_checker.sv
// Serial PRBS31 (x^31 + x^28 + 1) checker: self-seeds from the received stream,
// verifies before declaring lock, then flywheels and counts bit errors.
module prbs31_checker #(
    parameter int ERR_W       = 16,
    parameter int LOCK_THRESH = 64,
    parameter int WIN_LEN     = 128,
    parameter int UNLOCK_ERRS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             saturated,
    output logic             lock_lost
);

    localparam int GR_W = $clog2(LOCK_THRESH + 1);
    localparam int WC_W = $clog2(WIN_LEN);
    localparam int WE_W = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic [1:0] {
        SEED,
        VERIFY,
        LOCKED
    } state_t;

    state_t           state, state_n;
    logic [30:0]      hist, hist_n;
    logic [4:0]       seed_cnt, seed_cnt_n;
    logic [GR_W-1:0]  good_run, good_run_n;
    logic [WC_W-1:0]  win_cnt, win_cnt_n;
    logic [WE_W-1:0]  win_err, win_err_n;
    logic             err_pulse_n;
    logic [ERR_W-1:0] err_count_n;
    logic             saturated_n;
    logic             lock_lost_n;

    logic             expected;
    logic             mismatch;
    logic [WE_W-1:0]  win_err_inc;

    assign expected    = hist[27] ^ hist[30];
    assign mismatch    = din ^ expected;
    assign win_err_inc = win_err + WE_W'(mismatch);
    assign locked      = (state == LOCKED);

    // NOTE: the rst_n port is active-high here; every register, hist included,
    // takes a defined value so the checker never seeds from X.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= SEED;
            hist      <= '0;
            seed_cnt  <= '0;
            good_run  <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
            saturated <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so all
            // registers see the same pre-edge values.
            state     <= state_n;
            hist      <= hist_n;
            seed_cnt  <= seed_cnt_n;
            good_run  <= good_run_n;
            win_cnt   <= win_cnt_n;
            win_err   <= win_err_n;
            err_pulse <= err_pulse_n;
            err_count <= err_count_n;
            saturated <= saturated_n;
            lock_lost <= lock_lost_n;
        end
    end

    always_comb begin
        // NOTE: every next-state value is defaulted before any branch, which
        // keeps this block free of inferred latches.
        state_n     = state;
        hist_n      = hist;
        seed_cnt_n  = seed_cnt;
        good_run_n  = good_run;
        win_cnt_n   = win_cnt;
        win_err_n   = win_err;
        err_pulse_n = 1'b0;
        err_count_n = err_count;
        saturated_n = saturated;
        lock_lost_n = lock_lost;

        if (din_valid) begin
            unique case (state)
                SEED: begin
                    hist_n     = {hist[29:0], din};
                    seed_cnt_n = (seed_cnt == 5'd31) ? 5'd31 : seed_cnt + 5'd1;
                    // An all-zero history would self-predict zeros forever.
                    if (seed_cnt_n == 5'd31 && hist_n != '0) begin
                        state_n    = VERIFY;
                        good_run_n = '0;
                    end
                end

                VERIFY: begin
                    hist_n = {hist[29:0], din};
                    if (mismatch) begin
                        state_n    = SEED;
                        seed_cnt_n = 5'd1;
                    end else begin
                        good_run_n = good_run + GR_W'(1);
                        if (good_run_n == GR_W'(LOCK_THRESH)) begin
                            state_n   = LOCKED;
                            win_cnt_n = '0;
                            win_err_n = '0;
                        end
                    end
                end

                LOCKED: begin
                    // Flywheel: the reference follows its own prediction, so a
                    // channel error cannot corrupt later expectations.
                    hist_n      = {hist[29:0], expected};
                    err_pulse_n = mismatch;
                    if (mismatch && err_count != '1) begin
                        err_count_n = err_count + ERR_W'(1);
                        if (err_count_n == '1) saturated_n = 1'b1;
                    end
                    if (win_cnt == WC_W'(WIN_LEN - 1)) begin
                        win_cnt_n = '0;
                        win_err_n = '0;
                    end else begin
                        win_cnt_n = win_cnt + WC_W'(1);
                        win_err_n = win_err_inc;
                    end
                    if (win_err_inc >= WE_W'(UNLOCK_ERRS)) begin
                        state_n     = SEED;
                        seed_cnt_n  = '0;
                        lock_lost_n = 1'b1;
                    end
                end

                default: state_n = SEED;
            endcase
        end

        if (clear_cnt) begin
            err_count_n = '0;
            saturated_n = 1'b0;
        end
    end

endmodule

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
Serial PRBS31 checker (x^31 + x^28 + 1) that sits directly downstream of the team's PRBS31 generator. It consumes one bit per valid cycle and self-synchronises its reference register to the incoming stream. It declares lock, then counts bit errors and reports loss of lock. Used for loopback bit-error-rate testing on the tile pins.

Parameters:
ERR_W, 16, width of saturating error counter
LOCK_THRESH, 64, consecutive matching bits in VERIFY required to declare lock
WIN_LEN, 128, valid-bit window length for loss-of-lock evaluation
UNLOCK_ERRS, 8, errors within one window that force loss of lock

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset; synchronous, active-high (1 = reset) despite the name, per the codebase naming
din  in  1  received PRBS bit (generator's lfsr[30] output)
din_valid  in  1  din is sampled only when 1
clear_cnt  in  1  synchronous clear of err_count and saturated
locked  out  1  checker is in LOCKED state
err_pulse  out  1  one-cycle pulse per mismatching bit while LOCKED
err_count  out  ERR_W  saturating count of mismatches while LOCKED
saturated  out  1  sticky; err_count reached all-ones
lock_lost  out  1  sticky; a LOCKED->SEED transition has occurred since reset

Behaviour:
- Reset (rst_n=1 at clk edge): state=SEED; hist=0; seed_cnt=0; good_run=0; win_cnt=0; win_err=0.
- Reset values of outputs: locked=0, err_pulse=0, err_count=0, saturated=0, lock_lost=0. Reset overrides all other inputs.
- hist[30:0] holds prior bits; hist[0] is most recent. expected = hist[27] ^ hist[30].
- din_valid=0: no register changes except err_pulse, which clears to 0.
- Outputs are registered. Effects appear the cycle after the clk edge that accepted the bit.
- SEED:
  - Each valid bit: hist <= {hist[29:0], din}; seed_cnt increments, saturating at 31. No comparison is made.
  - Exit to VERIFY when seed_cnt==31 and the updated hist is nonzero; good_run=0.
  - If hist is all zero, stay in SEED and re-evaluate on every later valid bit. This prevents false lock on an idle-low line.
- VERIFY:
  - Each valid bit: shift din into hist.
  - din==expected: good_run++.
  - Mismatch: return to SEED with seed_cnt=1 (the bit is kept as a seed).
  - When good_run reaches LOCK_THRESH, go to LOCKED; locked=1, win_cnt=0, win_err=0.
- LOCKED (flywheel):
  - hist shifts in expected, not din, so each channel bit error is counted exactly once.
  - Mismatch: err_pulse=1 for one cycle; err_count++ saturating at 2^ERR_W-1; saturated set when all-ones is reached; win_err++.
  - win_cnt counts valid bits; when win_cnt == WIN_LEN-1, both win_cnt and win_err reset to 0 on that bit.
  - If the updated win_err reaches UNLOCK_ERRS: go to SEED with seed_cnt=0 and hist kept; locked=0; lock_lost=1.
  - The error that causes unlock is still counted and pulsed.
- err_count only changes in LOCKED. Errors in SEED/VERIFY are never counted.
- clear_cnt has priority over increment. A same-cycle error still pulses err_pulse, but err_count=0 and saturated=0 afterwards. clear_cnt does not affect state, locked, or lock_lost.
- Default lock latency on a clean stream: locked rises the cycle after the 95th valid bit (31 seed + 64 good).

Test Plan:
- Clean stream: reset, feed the generator output seeded with 1, din_valid=1 continuously.
  - The leading 30 zeros keep the checker in SEED; it seeds once hist is nonzero.
  - locked=1 exactly 1 cycle after bit 31+64 counted from the first nonzero-hist seed point.
  - After 10000 further bits: err_count=0, lock_lost=0.
- Single error: after lock, invert one bit.
  - Exactly one err_pulse, err_count=1, locked stays 1.
  - Next 1000 bits give no further pulses (flywheel).
- Idle line: din=0 for 500 valid bits → locked=0 throughout, state SEED, err_count=0.
- Burst error: after lock, invert 8 consecutive bits.
  - 8 err_pulses, err_count=8.
  - locked falls the cycle after the 8th error; lock_lost=1.
  - Relock occurs 95 valid bits after the clean stream resumes.
- Counter rules with ERR_W=4, UNLOCK_ERRS=8, WIN_LEN=128: inject 20 errors spaced 20 bits apart → err_count=15, saturated=1, locked stays 1.
  - Then assert clear_cnt in the same cycle as an error → err_pulse=1, err_count=0, saturated=0.
- Valid gaps and reset:
  - din_valid toggling 1/0 gives identical lock timing measured in valid bits.
  - Asserting rst_n for one cycle mid-LOCKED gives locked=0, err_count=0, lock_lost=0 on the next cycle.
